col_drain_ctrl: RTL

Parametrised successor to the per-column output controller in the systolic array. Captures one result per PE row per tile, arriving skewed in time, into a two-bank ping-pong buffer. Serialises each completed tile onto a single valid/ready output stream, so capture of tile N+1 overlaps drain of tile N. Sits between one array column and the column-output arbiter.

---
 rtl/col_drain_ctrl_if.sv | 27 ++
 rtl/col_drain_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/col_drain_ctrl_if.sv
// Column-drain bus: skewed per-row capture inputs plus the serialised valid/ready output stream.
// master = the drain controller, slave = the array column / arbiter side.
interface col_drain_ctrl_if #(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32
);
  logic [ROWS*OUTWIDTH-1:0] in_res;
  logic [ROWS-1:0]          in_valid;
  logic                     in_ready;
  logic [OUTWIDTH-1:0]      out_data;
  logic [$clog2(ROWS)-1:0]  out_row;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     overflow;
  logic                     busy;

  modport master (
    input  in_res, in_valid, out_ready,
    output in_ready, out_data, out_row, out_valid, out_last, overflow, busy
  );

  modport slave (
    output in_res, in_valid, out_ready,
    input  in_ready, out_data, out_row, out_valid, out_last, overflow, busy
  );
endinterface

// File: rtl/col_drain_ctrl.sv
// Per-column ping-pong capture buffer that serialises each completed tile onto one stream.
// Optional macro COL_DRAIN_OVFCNT_EN adds an 8-bit saturating dropped-row counter port ovf_cnt.
module col_drain_ctrl #(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  parameter int REVERSE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  col_drain_ctrl_if.master  bus
`ifdef COL_DRAIN_OVFCNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);
  localparam int IW = $clog2(ROWS);

  logic [ROWS-1:0]     cap_q [2];
  logic [ROWS-1:0]     cap_d [2];
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                overflow_q, overflow_d;
  logic [OUTWIDTH-1:0] mem_q [2][ROWS];

  logic                in_rdy;
  logic [ROWS-1:0]     cap_set;
  logic [ROWS-1:0]     drop;
  logic [ROWS-1:0]     cap_new;
  logic                fill;
  logic                xfer;
  logic                last;
  logic [IW-1:0]       phys;

  // Capture qualification depends only on registered state, so in_ready has no path from in_valid.
  always_comb begin
    in_rdy  = !full_q[wr_bank_q];
    cap_set = in_rdy ? (bus.in_valid & ~cap_q[wr_bank_q]) : '0;
    drop    = bus.in_valid & ~cap_set;
    cap_new = cap_q[wr_bank_q] | cap_set;
    fill    = in_rdy && (&cap_new);
    xfer    = full_q[rd_bank_q] && bus.out_ready;
    last    = (idx_q == IW'(ROWS-1));
    phys    = (REVERSE != 0) ? (IW'(ROWS-1) - idx_q) : idx_q;
  end

  always_comb begin
    cap_d      = cap_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    idx_d      = idx_q;
    overflow_d = overflow_q | (|drop);
    if (fill) begin
      cap_d[wr_bank_q]  = '0;
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end else begin
      cap_d[wr_bank_q]  = cap_new;
    end
    // A fill and a free never hit the same bank: fill needs it empty, free needs it full.
    if (xfer) begin
      if (last) begin
        idx_d             = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q[0]   <= '0;
      cap_q[1]   <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer storage carries no reset; cap/full decide what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (cap_set[i]) mem_q[wr_bank_q][i] <= bus.in_res[i*OUTWIDTH +: OUTWIDTH];
    end
  end

`ifdef COL_DRAIN_OVFCNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  function automatic int popcnt(input logic [ROWS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < ROWS; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  always_comb ovf_cnt_d = sat_add8(ovf_cnt_q, popcnt(drop));

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.out_data  = mem_q[rd_bank_q][phys];
  assign bus.out_row   = phys;
  assign bus.out_last  = full_q[rd_bank_q] && last;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = full_q[0] | full_q[1] | (|cap_q[wr_bank_q]);
endmodule
